ttt_input_accumulator: RTL and testbench
========================================

// Module: ttt_input_accumulator
// PURPOSE
//  Upstream stage of the TTT token processor. Latches token start/stop events from NUM_INPUTS
//  sources and weights each event by a programmable signed good/bad weight per source.
//  Once per time step it sums the weighted events into saturated good/bad deltas.
//  The deltas drive good_tokens_in/bad_tokens_in of the processor for its add-good/add-bad instrs.
// PARAMETERS
//  NUM_INPUTS      8   number of upstream token sources (power of 2, >=2)
//  INDEX_BITS      3   $clog2(NUM_INPUTS)
//  WEIGHT_BITS     4   signed weight width
//  NEW_TOKEN_BITS  4   signed output delta width (matches processor input)
// PORTS
//  clock            in   1               clock
//  reset            in   1               synchronous, active-high
//  start_in         in   NUM_INPUTS      per-source token_start pulses
//  stop_in          in   NUM_INPUTS      per-source token_stop pulses
//  step_start       in   1               begin accumulation for this time step
//  weight_we        in   1               write weight
//  weight_addr      in   INDEX_BITS      source index for write/read
//  weight_sel       in   1               0 = good weight, 1 = bad weight
//  weight_data_in   in   WEIGHT_BITS     signed weight to write
//  weight_data_out  out  WEIGHT_BITS     registered readback of [weight_addr][weight_sel]
//  busy             out  1               scan in progress
//  good_tokens_out  out  NEW_TOKEN_BITS  signed good delta, held until next step
//  bad_tokens_out   out  NEW_TOKEN_BITS  signed bad delta, held until next step
//  deltas_valid     out  1               1-cycle pulse when outputs update
// BEHAVIOUR
//  Reset: all weights 0, pending start/stop bits 0, FSM IDLE, busy=0, deltas_valid=0,
//   good/bad_tokens_out=0, weight_data_out=0. Reset mid-scan aborts the scan; no valid pulse.
//  Event capture, every cycle: pend_start[i] |= start_in[i]; pend_stop[i] |= stop_in[i].
//  FSM IDLE: step_start=1 -> SCAN, idx=0, both accumulators cleared. step_start is ignored while busy.
//  FSM SCAN, one source per cycle:
//   - net = pend_start[idx] - pend_stop[idx], so start+stop pending gives 0.
//   - acc_good += net*w_good[idx]; acc_bad += net*w_bad[idx].
//   - Clear pend bits [idx]. A new event on idx in the same cycle wins and stays pending.
//   - At idx=NUM_INPUTS-1 go to DONE; otherwise idx++.
//  FSM DONE: register the saturated accumulators to the outputs, deltas_valid=1 for one cycle, -> IDLE.
//  busy=1 in SCAN and DONE.
//  Latency: step_start sampled at cycle t -> deltas_valid high in cycle t+NUM_INPUTS+1.
//  Accumulators: signed, ACC_BITS = WEIGHT_BITS+INDEX_BITS+1, so they never overflow.
//   Output saturates to [-2^(NEW_TOKEN_BITS-1), 2^(NEW_TOKEN_BITS-1)-1].
//  Weight write: takes effect the next cycle. A scan reads the value stored at its read cycle.
//   A write to the index being scanned in the same cycle is not seen by that scan.
//  Readback: weight_data_out <= weight[weight_addr][weight_sel] each cycle; 1-cycle latency.
//   A simultaneous write returns the old value.
//  Events on stop without a prior start are still applied (-weight); no per-source state tracked.
// STRUCTURE
//  Shared package ttt_pkg: NEW_TOKEN_BITS, WEIGHT_BITS, typedef signed token_delta_t, weight_t,
//   enum accum_state_t {ACC_IDLE, ACC_SCAN, ACC_DONE}, and function sat_to_delta().
//  Sub-module ttt_weight_bank: 2 x NUM_INPUTS x WEIGHT_BITS register file with one write port,
//   a scan read port (idx) and a registered readback port.
// TESTING
//  1 After reset, step_start with no events -> deltas_valid at t+9, good=bad=0, busy back to 0.
//  2 w_good[2]=3, w_bad[5]=2; start_in[2], start_in[5]; step -> good=+3, bad=+2.
//    Then stop_in[2] and step -> good=-3, bad=0.
//  3 w_good[0..7]=7, start on all 8 -> good saturates to +7; w=-8 on all 8 -> -8.
//  4 start_in[1] and stop_in[1] in the same cycle with w_good[1]=4 -> good=0.
//  5 start_in[3] in the exact cycle idx=3 is scanned -> excluded now, counted next step.
//    step_start while busy -> ignored, only one valid pulse.
//  6 Reset asserted mid-SCAN -> no deltas_valid, outputs 0, pending cleared, weights 0.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and helpers for the TTT token datapath.
//   NEW_TOKEN_BITS : width of the signed good/bad deltas fed to the processor
//   WEIGHT_BITS    : width of the signed per-source weights
//   token_delta_t  : signed delta type
//   weight_t       : signed weight type
//   accum_state_t  : input accumulator FSM states
//   sat_to_delta() : clamps a signed sum into the token_delta_t range
package ttt_pkg;

  localparam int NEW_TOKEN_BITS = 4;
  localparam int WEIGHT_BITS    = 4;

  localparam int DELTA_MAX = (2 ** (NEW_TOKEN_BITS - 1)) - 1;
  localparam int DELTA_MIN = -(2 ** (NEW_TOKEN_BITS - 1));

  typedef logic signed [NEW_TOKEN_BITS-1:0] token_delta_t;
  typedef logic signed [WEIGHT_BITS-1:0]    weight_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_SCAN,
    ACC_DONE
  } accum_state_t;

  function automatic token_delta_t sat_to_delta(input int v);
    token_delta_t r;
    if (v > DELTA_MAX)      r = token_delta_t'(DELTA_MAX);
    else if (v < DELTA_MIN) r = token_delta_t'(DELTA_MIN);
    else                    r = token_delta_t'(v);
    return r;
  endfunction

endpackage

// File: rtl/ttt_weight_bank.sv
// Per-source good/bad weight register file.
//   i_clock, i_reset      : clock, synchronous active-high reset (all weights -> 0)
//   i_we/i_addr/i_sel/i_data : write port (sel 0 = good, 1 = bad); visible next cycle
//   i_scan_idx            : scan read index
//   o_scan_good/o_scan_bad: stored weights at i_scan_idx (combinational)
//   o_rd_data             : registered readback of [i_addr][i_sel]; old value on a
//                           simultaneous write
module ttt_weight_bank
  import ttt_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int INDEX_BITS = $clog2(NUM_INPUTS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_addr,
  input  logic                  i_sel,
  input  weight_t               i_data,
  input  logic [INDEX_BITS-1:0] i_scan_idx,
  output weight_t               o_scan_good,
  output weight_t               o_scan_bad,
  output weight_t               o_rd_data
);

  weight_t r_good [NUM_INPUTS];
  weight_t r_bad  [NUM_INPUTS];
  weight_t r_rd_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        r_good[i] <= '0;
        r_bad[i]  <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (i_we && !i_sel) r_good[i_addr] <= i_data;
      if (i_we &&  i_sel) r_bad[i_addr]  <= i_data;
      r_rd_data <= i_sel ? r_bad[i_addr] : r_good[i_addr];
    end
  end

  assign o_scan_good = r_good[i_scan_idx];
  assign o_scan_bad  = r_bad[i_scan_idx];
  assign o_rd_data   = r_rd_data;

endmodule

// File: rtl/ttt_input_accumulator.sv
// Latches per-source token start/stop events and, once per time step, scans all
// sources summing event * weight into saturated good/bad deltas.
//   clock, reset                 : clock, synchronous active-high reset
//   start_in, stop_in            : per-source event pulses (latched until scanned)
//   step_start                   : begin a scan (ignored while busy)
//   weight_we/addr/sel/data_in   : weight write port; weight_data_out is the
//                                  registered readback of [weight_addr][weight_sel]
//   busy                         : scan or output update in progress
//   good_tokens_out/bad_tokens_out : saturated deltas, held until next step
//   deltas_valid                 : one-cycle pulse when the deltas update
module ttt_input_accumulator
  import ttt_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int INDEX_BITS = $clog2(NUM_INPUTS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] start_in,
  input  logic [NUM_INPUTS-1:0] stop_in,
  input  logic                  step_start,
  input  logic                  weight_we,
  input  logic [INDEX_BITS-1:0] weight_addr,
  input  logic                  weight_sel,
  input  weight_t               weight_data_in,
  output weight_t               weight_data_out,
  output logic                  busy,
  output token_delta_t          good_tokens_out,
  output token_delta_t          bad_tokens_out,
  output logic                  deltas_valid
);

  localparam int ACC_BITS = WEIGHT_BITS + INDEX_BITS + 1;
  typedef logic signed [ACC_BITS-1:0] acc_t;

  accum_state_t          r_state, w_state_nxt;
  logic [INDEX_BITS-1:0] r_idx;
  logic [NUM_INPUTS-1:0] r_pend_start, r_pend_stop;
  acc_t                  r_acc_good, r_acc_bad;
  token_delta_t          r_good_out, r_bad_out;

  weight_t               w_scan_good, w_scan_bad;
  acc_t                  w_good_ext, w_bad_ext;
  acc_t                  w_acc_good_nxt, w_acc_bad_nxt;
  logic                  w_net_pos, w_net_neg, w_last;
  logic [NUM_INPUTS-1:0] w_clr;

  ttt_weight_bank #(
    .NUM_INPUTS (NUM_INPUTS),
    .INDEX_BITS (INDEX_BITS)
  ) u_bank (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_we        (weight_we),
    .i_addr      (weight_addr),
    .i_sel       (weight_sel),
    .i_data      (weight_data_in),
    .i_scan_idx  (r_idx),
    .o_scan_good (w_scan_good),
    .o_scan_bad  (w_scan_bad),
    .o_rd_data   (weight_data_out)
  );

  // Start and stop both pending cancel out (net 0).
  assign w_net_pos = r_pend_start[r_idx] & ~r_pend_stop[r_idx];
  assign w_net_neg = r_pend_stop[r_idx]  & ~r_pend_start[r_idx];
  assign w_last    = (r_idx == INDEX_BITS'(NUM_INPUTS - 1));
  assign w_clr     = (r_state == ACC_SCAN) ? (NUM_INPUTS'(1) << r_idx) : '0;

  assign w_good_ext = {{(ACC_BITS-WEIGHT_BITS){w_scan_good[WEIGHT_BITS-1]}}, w_scan_good};
  assign w_bad_ext  = {{(ACC_BITS-WEIGHT_BITS){w_scan_bad[WEIGHT_BITS-1]}}, w_scan_bad};

  always_comb begin
    w_acc_good_nxt = r_acc_good;
    w_acc_bad_nxt  = r_acc_bad;
    if (w_net_pos) begin
      w_acc_good_nxt = r_acc_good + w_good_ext;
      w_acc_bad_nxt  = r_acc_bad  + w_bad_ext;
    end else if (w_net_neg) begin
      w_acc_good_nxt = r_acc_good - w_good_ext;
      w_acc_bad_nxt  = r_acc_bad  - w_bad_ext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ACC_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b0;
    deltas_valid = 1'b0;
    case (r_state)
      ACC_IDLE: if (step_start) w_state_nxt = ACC_SCAN;
      ACC_SCAN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ACC_DONE;
      end
      ACC_DONE: begin
        busy         = 1'b1;
        deltas_valid = 1'b1;
        w_state_nxt  = ACC_IDLE;
      end
      default: w_state_nxt = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx        <= '0;
      r_pend_start <= '0;
      r_pend_stop  <= '0;
      r_acc_good   <= '0;
      r_acc_bad    <= '0;
      r_good_out   <= '0;
      r_bad_out    <= '0;
    end else begin
      // Clearing the scanned bit loses to a new event arriving in the same cycle.
      r_pend_start <= (r_pend_start & ~w_clr) | start_in;
      r_pend_stop  <= (r_pend_stop  & ~w_clr) | stop_in;
      case (r_state)
        ACC_IDLE: if (step_start) begin
          r_idx      <= '0;
          r_acc_good <= '0;
          r_acc_bad  <= '0;
        end
        ACC_SCAN: begin
          r_acc_good <= w_acc_good_nxt;
          r_acc_bad  <= w_acc_bad_nxt;
          r_idx      <= r_idx + INDEX_BITS'(1);
          // Outputs load on the edge into DONE so they are already stable while
          // deltas_valid is high.
          if (w_last) begin
            r_good_out <= sat_to_delta(int'(w_acc_good_nxt));
            r_bad_out  <= sat_to_delta(int'(w_acc_bad_nxt));
          end
        end
        default: ;
      endcase
    end
  end

  assign good_tokens_out = r_good_out;
  assign bad_tokens_out  = r_bad_out;

endmodule

// File: tb/tb_ttt_input_accumulator.sv
module tb_ttt_input_accumulator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] start_in = '0;
  logic [7:0] stop_in = '0;
  logic       step_start = 1'b0;
  logic       weight_we = 1'b0;
  logic [2:0] weight_addr = '0;
  logic       weight_sel = 1'b0;
  logic [3:0] weight_data_in = '0;
  logic [3:0] weight_data_out;
  logic       busy;
  logic [3:0] good_tokens_out;
  logic [3:0] bad_tokens_out;
  logic       deltas_valid;

  int n_checks = 0;
  int n_fail   = 0;

  ttt_input_accumulator #(.NUM_INPUTS(8), .INDEX_BITS(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .start_in        (start_in),
    .stop_in         (stop_in),
    .step_start      (step_start),
    .weight_we       (weight_we),
    .weight_addr     (weight_addr),
    .weight_sel      (weight_sel),
    .weight_data_in  (weight_data_in),
    .weight_data_out (weight_data_out),
    .busy            (busy),
    .good_tokens_out (good_tokens_out),
    .bad_tokens_out  (bad_tokens_out),
    .deltas_valid    (deltas_valid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_w(input logic [2:0] a, input logic s, input logic [3:0] d);
    weight_we = 1'b1; weight_addr = a; weight_sel = s; weight_data_in = d;
    tick();
    weight_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] st, input logic [7:0] sp);
    start_in = st; stop_in = sp;
    tick();
    start_in = '0; stop_in = '0;
  endtask

  // Issues step_start, then waits (bounded) for deltas_valid; cyc = cycles after SCAN entry.
  task automatic run_step(output int cyc);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    cyc = 0;
    while (deltas_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (deltas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", deltas_valid); end
    n_checks++; if (good_tokens_out !== 4'h0 || bad_tokens_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_outs got %h/%h exp 0/0", good_tokens_out, bad_tokens_out); end
    n_checks++; if (weight_data_out !== 4'h0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", weight_data_out); end
    run_step(cyc);
    n_checks++; if (cyc !== 8 || deltas_valid !== 1'b1) begin
      n_fail++; $display("FAIL empty_latency got %0d valid %b exp 8 valid 1", cyc, deltas_valid); end
    n_checks++; if (good_tokens_out !== 4'h0 || bad_tokens_out !== 4'h0) begin
      n_fail++; $display("FAIL empty_deltas got %h/%h exp 0/0", good_tokens_out, bad_tokens_out); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_busy got %b exp 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0 || deltas_valid !== 1'b0) begin
      n_fail++; $display("FAIL after_done got busy %b valid %b exp 0 0", busy, deltas_valid); end
  endtask

  task automatic test_single();
    int cyc;
    write_w(3'd2, 1'b0, 4'd3);
    write_w(3'd5, 1'b1, 4'd2);
    pulse(8'b0010_0100, 8'h00);
    run_step(cyc);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL single_latency got %0d exp 8", cyc); end
    n_checks++; if (good_tokens_out !== 4'h3 || bad_tokens_out !== 4'h2) begin
      n_fail++; $display("FAIL single_start got %h/%h exp 3/2", good_tokens_out, bad_tokens_out); end
    tick();
    n_checks++; if (good_tokens_out !== 4'h3 || bad_tokens_out !== 4'h2) begin
      n_fail++; $display("FAIL single_hold got %h/%h exp 3/2", good_tokens_out, bad_tokens_out); end
    pulse(8'h00, 8'b0000_0100);
    run_step(cyc);
    n_checks++; if (good_tokens_out !== 4'hD || bad_tokens_out !== 4'h0) begin
      n_fail++; $display("FAIL single_stop got %h/%h exp d/0", good_tokens_out, bad_tokens_out); end
    tick();
  endtask

  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < 8; i++) write_w(3'(i), 1'b0, 4'd7);
    pulse(8'hFF, 8'h00);
    run_step(cyc);
    n_checks++; if (good_tokens_out !== 4'h7 || bad_tokens_out !== 4'h2) begin
      n_fail++; $display("FAIL sat_pos got %h/%h exp 7/2", good_tokens_out, bad_tokens_out); end
    tick();
    for (int i = 0; i < 8; i++) write_w(3'(i), 1'b0, 4'h8);
    pulse(8'hFF, 8'h00);
    run_step(cyc);
    n_checks++; if (good_tokens_out !== 4'h8 || bad_tokens_out !== 4'h2) begin
      n_fail++; $display("FAIL sat_neg got %h/%h exp 8/2", good_tokens_out, bad_tokens_out); end
    tick();
  endtask

  task automatic test_start_stop_same();
    int cyc;
    write_w(3'd1, 1'b0, 4'd4);
    pulse(8'b0000_0010, 8'b0000_0010);
    run_step(cyc);
    n_checks++; if (good_tokens_out !== 4'h0 || bad_tokens_out !== 4'h0) begin
      n_fail++; $display("FAIL start_stop_same got %h/%h exp 0/0", good_tokens_out, bad_tokens_out); end
    tick();
  endtask

  task automatic test_scan_race();
    int cyc;
    int pulses;
    // good[3] is -8 from the saturation test
    step_start = 1'b1;
    tick();                    // now scanning idx 0
    step_start = 1'b0;
    tick(); tick(); tick();    // now scanning idx 3
    start_in = 8'b0000_1000;
    step_start = 1'b1;
    tick();
    start_in = '0;
    step_start = 1'b0;
    cyc = 4;
    while (deltas_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL race_latency got %0d exp 8", cyc); end
    n_checks++; if (good_tokens_out !== 4'h0) begin
      n_fail++; $display("FAIL race_excluded got %h exp 0", good_tokens_out); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (deltas_valid === 1'b1) pulses++; end
    n_checks++; if (pulses !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_step_ignored got pulses %0d busy %b exp 0 0", pulses, busy); end
    run_step(cyc);
    n_checks++; if (good_tokens_out !== 4'h8) begin
      n_fail++; $display("FAIL race_next_step got %h exp 8", good_tokens_out); end
    tick();
  endtask

  task automatic test_readback();
    write_w(3'd6, 1'b1, 4'hD);
    weight_addr = 3'd6; weight_sel = 1'b1;
    tick();
    n_checks++; if (weight_data_out !== 4'hD) begin n_fail++; $display("FAIL readback got %h exp d", weight_data_out); end
    weight_sel = 1'b0;
    tick();
    n_checks++; if (weight_data_out !== 4'h8) begin n_fail++; $display("FAIL readback_good got %h exp 8", weight_data_out); end
    weight_sel = 1'b1; weight_we = 1'b1; weight_data_in = 4'h2;
    tick();
    weight_we = 1'b0;
    n_checks++; if (weight_data_out !== 4'hD) begin n_fail++; $display("FAIL readback_old got %h exp d", weight_data_out); end
    tick();
    n_checks++; if (weight_data_out !== 4'h2) begin n_fail++; $display("FAIL readback_new got %h exp 2", weight_data_out); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    int pulses;
    write_w(3'd0, 1'b0, 4'd5);
    pulse(8'b0000_0001, 8'h00);
    pulse(8'b0000_0001, 8'h00);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (deltas_valid === 1'b1) pulses++; end
    n_checks++; if (pulses !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_valid got pulses %0d busy %b exp 0 0", pulses, busy); end
    n_checks++; if (good_tokens_out !== 4'h0 || bad_tokens_out !== 4'h0) begin
      n_fail++; $display("FAIL abort_outs got %h/%h exp 0/0", good_tokens_out, bad_tokens_out); end
    weight_addr = 3'd0; weight_sel = 1'b0;
    tick();
    n_checks++; if (weight_data_out !== 4'h0) begin n_fail++; $display("FAIL abort_weights got %h exp 0", weight_data_out); end
    write_w(3'd0, 1'b0, 4'd5);
    run_step(cyc);
    n_checks++; if (cyc !== 8 || good_tokens_out !== 4'h0) begin
      n_fail++; $display("FAIL abort_pending got %0d/%h exp 8/0", cyc, good_tokens_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_start_stop_same();
    test_scan_race();
    test_readback();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
